// File: rtl/kernel_bram_writer_if.sv
// kernel_bram_writer_if: weight stream handshake plus BRAM0 write port.
interface kernel_bram_writer_if #(
    parameter int ADDR_WIDTH   = 10,
    parameter int WEIGHT_WIDTH = 8
);
    logic                    i_wt_valid;
    logic [WEIGHT_WIDTH-1:0] i_wt_data;
    logic                    o_wt_ready;
    logic                    o_bram_we;
    logic [ADDR_WIDTH-1:0]   o_bram_addr;
    logic [WEIGHT_WIDTH-1:0] o_bram_wdata;

    modport master (
        output i_wt_valid, i_wt_data,
        input  o_wt_ready, o_bram_we, o_bram_addr, o_bram_wdata
    );

    modport slave (
        input  i_wt_valid, i_wt_data,
        output o_wt_ready, o_bram_we, o_bram_addr, o_bram_wdata
    );
endinterface

// File: rtl/kernel_bram_writer.sv
// kernel_bram_writer: streams one KERNEL_SIZE^2 weight burst into BRAM0 from a programmed base.
module kernel_bram_writer #(
    parameter int KERNEL_SIZE       = 3,
    parameter int KERNEL_ADDR_WIDTH = 10,
    parameter int WEIGHT_WIDTH      = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [KERNEL_ADDR_WIDTH-1:0] i_start_addr,
    kernel_bram_writer_if.slave          wt,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err
);
    localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CW = $clog2(N + 1);
    localparam logic [KERNEL_ADDR_WIDTH:0] LAST_BASE = (KERNEL_ADDR_WIDTH + 1)'((1 << KERNEL_ADDR_WIDTH) - N);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                         state, state_d;
    logic [KERNEL_ADDR_WIDTH-1:0]   base, addr;
    logic [WEIGHT_WIDTH-1:0]        wdata;
    logic [CW-1:0]                  cnt;
    logic                           we, err, hs, start_ok, start_bad;

    // A base too close to the top of BRAM0 would wrap, so it is rejected up front.
    always_comb begin
        hs        = wt.i_wt_valid && state == WRITE;
        start_ok  = state == IDLE && i_start && {1'b0, i_start_addr} <= LAST_BASE;
        start_bad = state == IDLE && i_start && {1'b0, i_start_addr} > LAST_BASE;
        state_d   = start_ok ? WRITE
                  : (hs && cnt == CW'(N - 1)) ? DONE
                  : state == DONE ? IDLE
                  : state;
    end

    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) state <= IDLE;
        else        state <= state_d;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            base  <= '0;
            addr  <= '0;
            wdata <= '0;
            cnt   <= '0;
            we    <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= start_bad;
            we  <= hs;
            if (hs) begin
                addr  <= base + KERNEL_ADDR_WIDTH'(cnt);
                wdata <= wt.i_wt_data;
                cnt   <= cnt + CW'(1);
            end
            if (start_ok) begin
                base <= i_start_addr;
                cnt  <= '0;
            end
        end
    end

    assign wt.o_wt_ready   = state == WRITE;
    assign wt.o_bram_we    = we;
    assign wt.o_bram_addr  = addr;
    assign wt.o_bram_wdata = wdata;
    assign o_busy          = state != IDLE;
    assign o_done          = state == DONE;
    assign o_err           = err;
endmodule

// File: tb/tb_kernel_bram_writer.sv
// tb_kernel_bram_writer: random-stimulus bench comparing the writer against a cycle-level behavioural model.
module tb_kernel_bram_writer;
    localparam int KS = 3, AW = 10, WW = 8, N = KS * KS;
    localparam int LAST = (1 << AW) - N;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          busy, done, err;

    kernel_bram_writer_if #(.ADDR_WIDTH(AW), .WEIGHT_WIDTH(WW)) bus();

    kernel_bram_writer #(.KERNEL_SIZE(KS), .KERNEL_ADDR_WIDTH(AW), .WEIGHT_WIDTH(WW)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_start_addr(start_addr),
        .wt(bus), .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what each output must show in the cycle after every edge.
    bit            m_write, m_done, m_err, m_we, m_hs;
    logic [AW-1:0] m_base, m_addr;
    logic [WW-1:0] m_wdata;
    int            m_k, cyc;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        bit idle;
        if (!rst_n) begin
            m_write = 0; m_done = 0; m_err = 0; m_we = 0; m_hs = 0;
            m_addr = '0; m_wdata = '0; m_k = 0;
        end else begin
            idle    = !m_write && !m_done;
            m_hs    = bus.i_wt_valid && m_write;
            m_err   = idle && start && int'(start_addr) > LAST;
            m_we    = m_hs;
            m_done  = m_hs && m_k == N - 1;
            if (m_hs) begin
                m_addr  = m_base + AW'(m_k);
                m_wdata = bus.i_wt_data;
                m_k++;
            end
            if (m_done) m_write = 0;
            if (idle && start && int'(start_addr) <= LAST) begin
                m_write = 1; m_base = start_addr; m_k = 0;
            end
        end
    end

    logic [AW-1:0] wr_addr[$];
    logic [WW-1:0] wr_data[$];
    logic [WW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] done_addr;
    int            ndone = 0, nerr = 0, start_cyc = 0, done_span = 0;

    always @(negedge clk) begin
        chk("ready", 32'(bus.o_wt_ready), 32'(m_write));
        chk("busy",  32'(busy),           32'(m_write || m_done));
        chk("done",  32'(done),           32'(m_done));
        chk("err",   32'(err),            32'(m_err));
        chk("we",    32'(bus.o_bram_we),  32'(m_we));
        chk("addr",  32'(bus.o_bram_addr),  32'(m_addr));
        chk("wdata", 32'(bus.o_bram_wdata), 32'(m_wdata));
        if (rst_n && start && !m_write && !m_done && int'(start_addr) <= LAST) start_cyc = cyc;
        if (bus.o_bram_we) begin
            wr_addr.push_back(bus.o_bram_addr);
            wr_data.push_back(bus.o_bram_wdata);
            mem[bus.o_bram_addr] = bus.o_bram_wdata;
        end
        if (err) nerr++;
        if (done) begin
            ndone++;
            done_span = cyc - start_cyc + 1;
            done_addr = bus.o_bram_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(logic [AW-1:0] a);
        start = 1'b1;
        start_addr = a;
        tick();
        start = 1'b0;
    endtask

    task automatic send(int n, logic [WW-1:0] d0, int pct);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            do begin
                bus.i_wt_valid = $urandom_range(0, 99) < pct;
                bus.i_wt_data  = bus.i_wt_valid ? d0 + WW'(i) : WW'($urandom);
                tick();
                t++;
            end while (!m_hs && t < 200);
            if (!m_hs) chk("beat_timeout", 32'(0), 32'(1));
        end
        bus.i_wt_valid = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        int d, e;
        bus.i_wt_valid = 1'b0;
        bus.i_wt_data  = '0;
        for (int i = 0; i < 5; i++) begin
            start          = 1'($urandom);
            start_addr     = AW'($urandom);
            bus.i_wt_valid = 1'($urandom);
            bus.i_wt_data  = WW'($urandom);
            tick();
            chk("rst_ready", 32'(bus.o_wt_ready), 32'(0));
            chk("rst_we",    32'(bus.o_bram_we), 32'(0));
            chk("rst_addr",  32'(bus.o_bram_addr), 32'(0));
            chk("rst_busy",  32'(busy), 32'(0));
        end
        start = 1'b0;
        bus.i_wt_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'(0));

        clear_log();
        do_start(10'h010);
        send(9, 8'h01, 100);
        tick();
        chk("full_nwr", 32'(wr_addr.size()), 32'(9));
        chk("full_span", 32'(done_span), 32'(11));
        chk("full_done_addr", 32'(done_addr), 32'h018);
        for (int i = 0; i < 9; i++) chk("full_mem", 32'(mem[10'h010 + i]), 32'(i + 1));

        clear_log();
        do_start(10'h200);
        send(9, 8'hF0, 50);
        tick();
        chk("stall_nwr", 32'(wr_addr.size()), 32'(9));
        if (wr_addr.size() == 9) begin
            chk("stall_first", 32'(wr_addr[0]), 32'h200);
            for (int i = 1; i < 9; i++) chk("stall_incr", 32'(wr_addr[i]), 32'(wr_addr[i-1]) + 1);
            for (int i = 0; i < 9; i++) chk("stall_data", 32'(wr_data[i]), 32'(8'hF0 + i));
        end

        clear_log();
        e = nerr;
        do_start(10'h3F8);
        bus.i_wt_valid = 1'b1;
        tick();
        chk("rng_busy", 32'(busy), 32'(0));
        tick();
        bus.i_wt_valid = 1'b0;
        chk("rng_err", 32'(nerr - e), 32'(1));
        chk("rng_nwr", 32'(wr_addr.size()), 32'(0));
        do_start(10'h3F7);
        send(9, 8'h30, 100);
        tick();
        chk("rng_ok_nwr", 32'(wr_addr.size()), 32'(9));
        chk("rng_ok_top", 32'(mem[10'h3FF]), 32'h38);
        chk("rng_ok_done", 32'(done_addr), 32'h3FF);

        clear_log();
        e = nerr;
        d = ndone;
        do_start(10'h000);
        send(4, 8'hA0, 70);
        start = 1'b1;
        start_addr = 10'h100;
        tick();
        start = 1'b0;
        send(5, 8'hA4, 70);
        tick();
        chk("ign_nwr", 32'(wr_addr.size()), 32'(9));
        chk("ign_err", 32'(nerr - e), 32'(0));
        chk("ign_done", 32'(ndone - d), 32'(1));
        if (wr_addr.size() == 9)
            for (int i = 0; i < 9; i++) chk("ign_addr", 32'(wr_addr[i]), 32'(i));

        clear_log();
        d = ndone;
        do_start(10'h040);
        send(5, 8'h50, 100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we",    32'(bus.o_bram_we), 32'(0));
        chk("mid_rst_ready", 32'(bus.o_wt_ready), 32'(0));
        chk("mid_rst_busy",  32'(busy), 32'(0));
        chk("mid_rst_addr",  32'(bus.o_bram_addr), 32'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rst_done", 32'(ndone - d), 32'(0));
        chk("mid_rst_nwr", 32'(wr_addr.size()), 32'(4));
        chk("mid_rst_mem", 32'(mem[10'h043]), 32'h53);

        clear_log();
        do_start(10'h080);
        send(9, 8'h60, 100);
        tick();
        chk("post_nwr", 32'(wr_addr.size()), 32'(9));
        chk("post_span", 32'(done_span), 32'(11));
        chk("post_done_addr", 32'(done_addr), 32'h088);
        chk("post_mem", 32'(mem[10'h080]), 32'h60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kernel_bram_writer.md
# kernel_bram_writer

Write side of the kernel weight store. Accepts a KERNEL_SIZE×KERNEL_SIZE stream of weights from the host/DMA over a valid/ready handshake and writes them into the kernel BRAM (BRAM0) at consecutive addresses starting from a programmed base. It produces the image that the kernel register block later reads back from the same base address. One burst is loaded per `i_start`.

## Interface
Parameters:
- KERNEL_SIZE, 3: kernel edge length. Words per burst N = KERNEL_SIZE*KERNEL_SIZE.
- KERNEL_ADDR_WIDTH, 10: BRAM0 address width.
- WEIGHT_WIDTH, 8: weight word width.

Ports:
- i_clk  input  1  single clock. All logic is on the rising edge.
- i_rst  input  1  reset, asynchronous, active-low.
- i_start  input  1  single-cycle request to begin a burst. Sampled only in IDLE.
- i_start_addr  input  KERNEL_ADDR_WIDTH  BRAM0 base address. Captured with `i_start`.
- i_wt_valid  input  1  weight beat valid.
- i_wt_data  input  WEIGHT_WIDTH  weight beat data.
- o_wt_ready  output  1  block can accept a beat.
- o_bram_we  output  1  BRAM0 write enable.
- o_bram_addr  output  KERNEL_ADDR_WIDTH  BRAM0 write address.
- o_bram_wdata  output  WEIGHT_WIDTH  BRAM0 write data.
- o_busy  output  1  high in the WRITE and DONE states.
- o_done  output  1  one-cycle pulse when the burst completes.
- o_err  output  1  one-cycle pulse when a start is rejected.

## Operation
- FSM states: IDLE, WRITE, DONE.
- **IDLE:**
  - On `i_start`, check the range. If `i_start_addr` > 2^KERNEL_ADDR_WIDTH − N, the burst would wrap. In that case pulse `o_err` next cycle, stay in IDLE, and write nothing.
  - Otherwise latch the base, clear the beat counter (width clog2(N+1)) and go to WRITE.
- **WRITE:**
  - `o_wt_ready` = 1.
  - Each handshake (`i_wt_valid` && `o_wt_ready`) registers the data and the address base+k, where k is the beat index 0..N−1. It then increments k.
  - The handshake for k = N−1 moves the FSM to DONE. `o_wt_ready` is 0 from the next cycle.
  - Beats with `i_wt_valid` = 0 are stalls. There is no timeout.
- **DONE:** lasts exactly one cycle, with `o_done` = 1. The FSM then returns to IDLE.
- `i_start` is ignored in WRITE and DONE. There is no error and no restart.
- Address arithmetic is an unsigned add of base + k in KERNEL_ADDR_WIDTH bits. Overflow cannot occur because of the IDLE range check.
- Data is passed through unmodified. No sign handling.

## Timing
- Reset (`i_rst` low, asynchronous): FSM = IDLE, counter = 0.
  - All outputs are 0: `o_wt_ready`, `o_bram_we`, `o_bram_addr`, `o_bram_wdata`, `o_busy`, `o_done`, `o_err`.
  - Reset mid-burst abandons the burst. Words already written stay in BRAM. No `o_done` is produced.
- Start latency: `i_start` at cycle T (IDLE) gives state WRITE, `o_wt_ready` = 1 and `o_busy` = 1 at T+1.
- Write latency: a handshake at cycle t gives `o_bram_we` = 1 at t+1, with the matching `o_bram_addr` and `o_bram_wdata`. `o_bram_we` is 0 in every other cycle.
- Back-to-back beats give one BRAM write per cycle. Minimum burst is N+2 cycles from `i_start` to `o_done`.
- `o_done` is asserted in the same cycle as the last `o_bram_we` (address base+N−1).
- The next `i_start` is accepted from the cycle after `o_done`.
- Rejected start: `i_start` at T gives `o_err` = 1 at T+1. `o_busy` stays 0 and `o_wt_ready` stays 0.
- A valid beat arriving while `o_wt_ready` = 0 is not consumed. The source must hold it.

## Test plan
1. **Reset values:** hold `i_rst` = 0 with random inputs. All outputs read 0. Release reset and the FSM is in IDLE (`o_busy` = 0).
2. **Full-rate burst:** KERNEL_SIZE = 3, base = 0x010, 9 beats with `i_wt_valid` always high, data 0x01..0x09.
   - Writes go to 0x010..0x018 with data 0x01..0x09 on consecutive cycles.
   - `o_done` coincides with the write to 0x018.
   - Total is 11 cycles from `i_start` to `o_done`.
3. **Back-pressure/stalls:** random `i_wt_valid` gaps, data 0xF0..0xF8.
   - Exactly 9 writes, addresses strictly increasing by 1.
   - No write occurs in a cycle following a non-handshake.
   - Data order is preserved.
4. **Range check:**
   - base = 0x3F8 (1024−9 = 0x3F7 is the last legal base) gives an `o_err` pulse, no writes, and FSM stays in IDLE.
   - base = 0x3F7 is accepted and writes 0x3F7..0x3FF.
5. **Start during burst and reset mid-burst:**
   - `i_start` with base 0x100 issued after 4 beats of a base-0x000 burst is ignored. The remaining writes go to 0x004..0x008.
   - Asserting `i_rst` after 5 beats gives 0 on all outputs immediately and no `o_done`. A new burst then runs cleanly from its own base.
